// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the 1-to-16 serial demux.
package demux_pkg;
  localparam int LANES = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_e;
endpackage

// File: rtl/demux_1x16_dec.sv
// Enable-gated index to one-hot lane write-enable decoder.
import demux_pkg::*;

module demux_1x16_dec #(
  parameter int LANES = demux_pkg::LANES,
  parameter int SEL_W = demux_pkg::SEL_W
) (
  input  logic             en_i,
  input  logic [SEL_W-1:0] idx_i,
  output logic [LANES-1:0] oh_o
);

  always_comb begin
    oh_o = '0;
    if (en_i) oh_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/demux_1x16_deser.sv
// Serial-to-parallel demux: addressed lane writes or 16-bit scan
// capture presented with a valid/ready handshake.
import demux_pkg::*;

module demux_1x16_deser #(
  parameter int LANES = demux_pkg::LANES,
  parameter int SEL_W = demux_pkg::SEL_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  input  logic             start_i,
  input  logic             wr_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [LANES-1:0] lanes_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             busy_o,
  output logic [SEL_W-1:0] slot_o,
  output logic             overrun_o
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [LANES-1:0] shadow_q, shadow_d;
  logic [LANES-1:0] lanes_q, lanes_d;
  logic             valid_q, busy_q, ovr_q;
  logic             drop;
  logic             wr_en, sh_en;
  logic [LANES-1:0] wr_oh, sh_oh;
  logic [LANES-1:0] bit_rep;

  assign bit_rep = {LANES{bit_i}};
  assign wr_en   = (state_q == IDLE) & wr_i & ~start_i;
  assign sh_en   = (state_q == SHIFT) & bit_valid_i;

  demux_1x16_dec #(
    .LANES(LANES),
    .SEL_W(SEL_W)
  ) u_wr_dec (
    .en_i (wr_en),
    .idx_i(sel_i),
    .oh_o (wr_oh)
  );

  demux_1x16_dec #(
    .LANES(LANES),
    .SEL_W(SEL_W)
  ) u_sh_dec (
    .en_i (sh_en),
    .idx_i(slot_q),
    .oh_o (sh_oh)
  );

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = (shadow_q & ~sh_oh) | (sh_oh & bit_rep);
    lanes_d  = (lanes_q & ~wr_oh) | (wr_oh & bit_rep);
    drop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        drop = start_i & wr_i;
        if (start_i) begin
          state_d  = SHIFT;
          slot_d   = '0;
          shadow_d = '0;
        end
      end
      SHIFT: begin
        drop = start_i | wr_i;
        if (bit_valid_i) begin
          slot_d = slot_q + SEL_W'(1);
          if (slot_q == SEL_W'(LANES - 1)) begin
            lanes_d = shadow_d;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        drop = wr_i | (start_i & ~word_ready_i);
        if (word_ready_i) begin
          state_d = start_i ? SHIFT : IDLE;
          slot_d  = '0;
          if (start_i) shadow_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      shadow_q <= '0;
      lanes_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      lanes_q  <= lanes_d;
      valid_q  <= (state_d == HOLD);
      busy_q   <= (state_d != IDLE);
      ovr_q    <= drop;
    end
  end

  assign lanes_o      = lanes_q;
  assign word_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign slot_o       = slot_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_demux_1x16_deser.sv
// Scenario bench for demux_1x16_deser against a word-level lane model.
module tb_demux_1x16_deser;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        bit_i = 1'b0;
  logic        bit_valid_i = 1'b0;
  logic        start_i = 1'b0;
  logic        wr_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic [15:0] lanes_o;
  logic        word_valid_o;
  logic        word_ready_i = 1'b0;
  logic        busy_o;
  logic [3:0]  slot_o;
  logic        overrun_o;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_lanes = '0;

  demux_1x16_deser dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .bit_i       (bit_i),
    .bit_valid_i (bit_valid_i),
    .start_i     (start_i),
    .wr_i        (wr_i),
    .sel_i       (sel_i),
    .lanes_o     (lanes_o),
    .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i),
    .busy_o      (busy_o),
    .slot_o      (slot_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Sends bits lo..hi of w LSB first; gap_pct>0 inserts random idle cycles.
  task automatic send_range(input logic [15:0] w, input int lo, input int hi,
                            input int gap_pct);
    for (int i = lo; i <= hi; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bit_valid_i = 1'b0;
        bit_i = 1'($urandom);
        step();
      end
      bit_valid_i = 1'b1;
      bit_i = w[i];
      step();
    end
    bit_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (lanes_o !== 16'h0) begin bad++; $display("FAIL rst_lanes got=%h exp=0000", lanes_o); end
    total++; if ({word_valid_o, busy_o, overrun_o, slot_o} !== 7'b0) begin bad++; $display("FAIL rst_ctrl got=%b exp=0", {word_valid_o, busy_o, overrun_o, slot_o}); end
    #3 rst_ni = 1'b1;
    step();
    wr_i = 1'b1; sel_i = 4'd3; bit_i = 1'b1;
    step();
    wr_i = 1'b0;
    total++; if (lanes_o !== 16'h0008) begin bad++; $display("FAIL pre_rst_wr got=%h exp=0008", lanes_o); end
    do_start();
    #2 rst_ni = 1'b0;
    #1;
    total++; if (lanes_o !== 16'h0) begin bad++; $display("FAIL async_rst_lanes got=%h exp=0000", lanes_o); end
    total++; if ({word_valid_o, busy_o, slot_o} !== 6'b0) begin bad++; $display("FAIL async_rst_ctrl got=%b exp=0", {word_valid_o, busy_o, slot_o}); end
    #2 rst_ni = 1'b1;
    exp_lanes = '0;
    step();
  endtask

  task automatic test_addr_write();
    wr_i = 1'b1; sel_i = 4'd5; bit_i = 1'b1;
    step();
    exp_lanes[5] = 1'b1;
    total++; if (lanes_o !== 16'h0020) begin bad++; $display("FAIL wr_sel5 got=%h exp=0020", lanes_o); end
    sel_i = 4'd15;
    step();
    wr_i = 1'b0;
    exp_lanes[15] = 1'b1;
    total++; if (lanes_o !== 16'h8020) begin bad++; $display("FAIL wr_sel15 got=%h exp=8020", lanes_o); end
    total++; if ({busy_o, overrun_o} !== 2'b00) begin bad++; $display("FAIL wr_ctrl got=%b exp=00", {busy_o, overrun_o}); end
  endtask

  task automatic test_scan_backpressure();
    logic [15:0] w = 16'hA5C3;
    do_start();
    total++; if (busy_o !== 1'b1 || slot_o !== 4'd0) begin bad++; $display("FAIL start_state got=%b/%h exp=1/0", busy_o, slot_o); end
    send_range(w, 0, 7, 0);
    total++; if (lanes_o !== exp_lanes || slot_o !== 4'd8) begin bad++; $display("FAIL mid_shift got=%h/%h exp=%h/8", lanes_o, slot_o, exp_lanes); end
    send_range(w, 8, 15, 0);
    exp_lanes = w;
    for (int c = 0; c < 5; c++) begin
      total++; if (word_valid_o !== 1'b1 || lanes_o !== exp_lanes) begin bad++; $display("FAIL hold_%0d got=%b/%h exp=1/%h", c, word_valid_o, lanes_o, exp_lanes); end
      step();
    end
    word_ready_i = 1'b1;
    step();
    word_ready_i = 1'b0;
    total++; if (word_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL handshake got=%b%b exp=00", word_valid_o, busy_o); end
    total++; if (lanes_o !== 16'hA5C3) begin bad++; $display("FAIL post_hs_lanes got=%h exp=a5c3", lanes_o); end
  endtask

  task automatic test_gapped_back_to_back();
    logic [15:0] w = 16'h1234;
    int i = 0;
    int cyc = 0;
    do_start();
    while (i < 16) begin
      bit_valid_i = (cyc % 3) != 2;
      bit_i = bit_valid_i ? w[i] : 1'b1;
      step();
      if (bit_valid_i) i++;
      cyc++;
      if (i < 16) begin
        total++; if (slot_o !== 4'(i)) begin bad++; $display("FAIL gap_slot_c%0d got=%h exp=%h", cyc, slot_o, 4'(i)); end
      end
    end
    bit_valid_i = 1'b0;
    exp_lanes = w;
    total++; if (word_valid_o !== 1'b1 || lanes_o !== exp_lanes) begin bad++; $display("FAIL gap_word got=%b/%h exp=1/%h", word_valid_o, lanes_o, exp_lanes); end
    word_ready_i = 1'b1; start_i = 1'b1;
    step();
    word_ready_i = 1'b0; start_i = 1'b0;
    total++; if ({word_valid_o, busy_o, overrun_o} !== 3'b010 || slot_o !== 4'd0) begin bad++; $display("FAIL b2b_restart got=%b/%h exp=010/0", {word_valid_o, busy_o, overrun_o}, slot_o); end
    send_range(16'hFFFF, 0, 15, 0);
    exp_lanes = 16'hFFFF;
    total++; if (word_valid_o !== 1'b1 || lanes_o !== exp_lanes) begin bad++; $display("FAIL b2b_word got=%b/%h exp=1/ffff", word_valid_o, lanes_o); end
    word_ready_i = 1'b1;
    step();
    word_ready_i = 1'b0;
  endtask

  task automatic test_overrun();
    logic [15:0] w = 16'($urandom);
    do_start();
    send_range(w, 0, 6, 0);
    total++; if (slot_o !== 4'd7) begin bad++; $display("FAIL ovr_slot got=%h exp=7", slot_o); end
    wr_i = 1'b1; sel_i = 4'd2; bit_i = w[7]; bit_valid_i = 1'b1;
    step();
    wr_i = 1'b0; bit_valid_i = 1'b0;
    total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b exp=1", overrun_o); end
    total++; if (lanes_o !== exp_lanes) begin bad++; $display("FAIL ovr_lanes got=%h exp=%h", lanes_o, exp_lanes); end
    step();
    total++; if (overrun_o !== 1'b0 || slot_o !== 4'd8) begin bad++; $display("FAIL ovr_end got=%b/%h exp=0/8", overrun_o, slot_o); end
    send_range(w, 8, 15, 0);
    exp_lanes = w;
    total++; if (word_valid_o !== 1'b1 || lanes_o !== exp_lanes) begin bad++; $display("FAIL ovr_word got=%b/%h exp=1/%h", word_valid_o, lanes_o, exp_lanes); end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    total++; if (overrun_o !== 1'b1 || word_valid_o !== 1'b1) begin bad++; $display("FAIL hold_start_drop got=%b%b exp=11", overrun_o, word_valid_o); end
    word_ready_i = 1'b1;
    step();
    word_ready_i = 1'b0;
    total++; if ({overrun_o, busy_o} !== 2'b00) begin bad++; $display("FAIL ovr_done got=%b exp=00", {overrun_o, busy_o}); end
  endtask

  task automatic test_reset_mid_scan();
    logic [15:0] w = 16'($urandom);
    do_start();
    send_range(w, 0, 6, 0);
    total++; if (slot_o !== 4'd7) begin bad++; $display("FAIL rms_slot got=%h exp=7", slot_o); end
    #2 rst_ni = 1'b0;
    #1;
    exp_lanes = '0;
    total++; if ({word_valid_o, busy_o, slot_o} !== 6'b0 || lanes_o !== 16'h0) begin bad++; $display("FAIL rms_zero got=%b/%h exp=0/0000", {word_valid_o, busy_o, slot_o}, lanes_o); end
    #2 rst_ni = 1'b1;
    step();
    total++; if (busy_o !== 1'b0 || word_valid_o !== 1'b0) begin bad++; $display("FAIL rms_idle got=%b%b exp=00", busy_o, word_valid_o); end
    do_start();
    send_range(16'h00FF, 0, 15, 0);
    exp_lanes = 16'h00FF;
    total++; if (word_valid_o !== 1'b1 || lanes_o !== exp_lanes) begin bad++; $display("FAIL rms_word got=%b/%h exp=1/00ff", word_valid_o, lanes_o); end
    word_ready_i = 1'b1;
    step();
    word_ready_i = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int op = $urandom_range(0, 2);
      if (op == 0) begin
        logic [3:0] s = 4'($urandom);
        logic b = 1'($urandom);
        wr_i = 1'b1; sel_i = s; bit_i = b; bit_valid_i = 1'($urandom);
        step();
        wr_i = 1'b0; bit_valid_i = 1'b0;
        exp_lanes[s] = b;
        total++; if (lanes_o !== exp_lanes || overrun_o !== 1'b0) begin bad++; $display("FAIL rnd_wr_%0d got=%h/%b exp=%h/0", n, lanes_o, overrun_o, exp_lanes); end
      end else if (op == 1) begin
        logic [15:0] w = 16'($urandom);
        int d = $urandom_range(0, 3);
        do_start();
        send_range(w, 0, 15, 25);
        exp_lanes = w;
        for (int c = 0; c < d; c++) step();
        total++; if (word_valid_o !== 1'b1 || lanes_o !== exp_lanes) begin bad++; $display("FAIL rnd_scan_%0d got=%b/%h exp=1/%h", n, word_valid_o, lanes_o, exp_lanes); end
        word_ready_i = 1'b1;
        step();
        word_ready_i = 1'b0;
        total++; if (word_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL rnd_hs_%0d got=%b%b exp=00", n, word_valid_o, busy_o); end
      end else begin
        bit_valid_i = 1'b1; bit_i = 1'($urandom); word_ready_i = 1'b1;
        step();
        bit_valid_i = 1'b0; word_ready_i = 1'b0;
        total++; if (lanes_o !== exp_lanes || {overrun_o, busy_o, word_valid_o} !== 3'b000) begin bad++; $display("FAIL rnd_stray_%0d got=%h/%b exp=%h/000", n, lanes_o, {overrun_o, busy_o, word_valid_o}, exp_lanes); end
      end
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_addr_write();
    test_scan_backpressure();
    test_gapped_back_to_back();
    test_overrun();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
